// File: rtl/trig_burst_streamer_pkg.sv
// Shared types and default parameters for the trigger-driven burst streamer.
package trig_burst_streamer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_BURST_LEN  = 32;
  localparam int DEF_CLK_DIV    = 2;

  // Counter width for a range 0..v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/trig_burst_streamer_if.sv
// AXI4-Stream sample bus (tdata/tvalid/tready) between streamer and sink.
interface trig_burst_streamer_if
  import trig_burst_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input  tready);
  modport slave  (input  tdata, input  tvalid, output tready);

endinterface

// File: rtl/trig_burst_streamer_trig_sync_edge.sv
// Two-flop synchronizer for the async trigger, rising-edge detect and
// registered one-cycle trigger pulse.
module trig_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic trig_i,
  output logic edge_o,
  output logic trig_pulse_o
);

  logic s1_q, s2_q, s3_q, pulse_q;

  // Synchronizer chain, history flop and pulse register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= trig_i;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      pulse_q <= s2_q & ~s3_q;
    end
  end

  assign edge_o       = s2_q & ~s3_q;
  assign trig_pulse_o = pulse_q;

endmodule

// File: rtl/trig_burst_streamer.sv
// Trigger-driven AXI4-Stream ramp burst generator with a free-running
// divided-clock indicator output.
module trig_burst_streamer
  import trig_burst_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int CLK_DIV    = DEF_CLK_DIV
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  trig,
  output logic                  trig_out,
  output logic                  clk_out1,
  trig_burst_streamer_if.master M_AXIS
);

  localparam int               IDX_W    = clog2_min1(BURST_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BURST_LEN - 1);
  localparam int               CNT_W    = clog2_min1(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic                  trig_edge;
  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  accept;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  clk_div_q, clk_div_d;

  trig_sync_edge u_sync (
    .clk_i        (aclk),
    .rst_ni       (aresetn),
    .trig_i       (trig),
    .edge_o       (trig_edge),
    .trig_pulse_o (trig_out)
  );

  assign accept = tvalid_q & M_AXIS.tready;

  // Burst FSM next state and registered stream outputs.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    unique case (state_q)
      IDLE: begin
        if (trig_edge) begin
          state_d  = BURST;
          idx_d    = '0;
          tdata_d  = '0;
          tvalid_d = 1'b1;
        end
      end
      BURST: begin
        // Edges arriving here are not queued; only beat acceptance matters.
        if (accept) begin
          if (idx_q == IDX_LAST) begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            tdata_d = tdata_q + DATA_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and stream output registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
    end
  end

  // Divider next state: toggle and clear at terminal count.
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    clk_div_d = clk_div_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d     = '0;
      clk_div_d = ~clk_div_q;
    end
  end

  // Divider registers, free-running and independent of the trigger.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q     <= '0;
      clk_div_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_div_q <= clk_div_d;
    end
  end

  assign clk_out1      = clk_div_q;
  assign M_AXIS.tdata  = tdata_q;
  assign M_AXIS.tvalid = tvalid_q;

endmodule

// File: tb/tb_trig_burst_streamer.sv
// Scoreboard bench for trig_burst_streamer: a trigger-history model pushes
// expected ramp beats, a negedge monitor pops and compares presented beats.
module tb_trig_burst_streamer;

  localparam int DW = 16;
  localparam int BL = 32;
  localparam int CD = 2;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  logic trig    = 1'b0;
  logic trig_out;
  logic clk_out1;

  trig_burst_streamer_if #(.DATA_WIDTH(DW)) axis ();

  trig_burst_streamer #(
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL),
    .CLK_DIV    (CD)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .trig     (trig),
    .trig_out (trig_out),
    .clk_out1 (clk_out1),
    .M_AXIS   (axis)
  );

  always #4 aclk = ~aclk;

  int unsigned   vectors     = 0;
  int unsigned   miscompares = 0;
  logic [DW-1:0] exp_q[$];
  logic [3:0]    hist        = '0;
  logic          exp_pulse   = 1'b0;
  logic          start_burst;
  int unsigned   cyc         = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor + model. At each negedge outputs reflect the last posedge;
  // then the model predicts what the upcoming posedge will do.
  always @(negedge aclk) begin
    if (!aresetn) begin
      check("rst_tvalid", {31'b0, axis.tvalid}, 0);
      check("rst_tdata", {16'b0, axis.tdata}, 0);
      check("rst_trig_out", {31'b0, trig_out}, 0);
      check("rst_clk_out1", {31'b0, clk_out1}, 0);
      exp_q.delete();
      hist      = '0;
      exp_pulse = 1'b0;
      cyc       = 0;
    end else begin
      check("trig_out", {31'b0, trig_out}, {31'b0, exp_pulse});
      check("tvalid", {31'b0, axis.tvalid}, {31'b0, (exp_q.size() != 0)});
      if (axis.tvalid && exp_q.size() != 0)
        check("tdata", {16'b0, axis.tdata}, {16'b0, exp_q[0]});
      check("clk_out1", {31'b0, clk_out1}, (cyc / CD) % 2);
      // trig is stable here and is what the next posedge samples.
      hist        = {hist[2:0], trig};
      exp_pulse   = hist[2] & ~hist[3];
      start_burst = exp_pulse && (exp_q.size() == 0);
      if (exp_q.size() != 0 && axis.tready) void'(exp_q.pop_front());
      if (start_burst)
        for (int i = 0; i < BL; i++) exp_q.push_back(DW'(i));
      cyc++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge aclk);
    #2;
  endtask

  task automatic wait_beat(input logic [DW-1:0] v, input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge aclk);
      if (axis.tvalid && axis.tdata == v) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_beat: tdata %0d not presented within %0d cycles", v, budget);
  endtask

  initial begin
    axis.tready = 1'b1;
    #54;
    aresetn = 1'b1;
    cycles(10);

    // Single burst, full throughput.
    trig = 1'b1; cycles(40); trig = 1'b0; cycles(4);

    // Burst starting under backpressure.
    axis.tready = 1'b0; trig = 1'b1; cycles(8);
    axis.tready = 1'b1; cycles(40); trig = 1'b0; cycles(4);

    // Five-cycle stall holding tdata=10.
    trig = 1'b1;
    wait_beat(DW'(9), 20);
    @(posedge aclk); #2;
    axis.tready = 1'b0; cycles(5);
    axis.tready = 1'b1; cycles(40); trig = 1'b0; cycles(4);

    // Re-trigger during a burst is ignored, after it starts a new one.
    trig = 1'b1; cycles(10); trig = 1'b0; cycles(3);
    trig = 1'b1; cycles(3);  trig = 1'b0; cycles(30);
    trig = 1'b1; cycles(40); trig = 1'b0; cycles(4);

    // Random trigger activity and backpressure.
    repeat (3000) begin
      cycles(1);
      axis.tready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) trig = ~trig;
    end
    trig = 1'b0; axis.tready = 1'b1; cycles(40);

    // Reset mid-burst with trig held high through release.
    trig = 1'b1;
    wait_beat(DW'(7), 20);
    #1 aresetn = 1'b0;
    #1;
    check("arst_tvalid", {31'b0, axis.tvalid}, 0);
    check("arst_tdata", {16'b0, axis.tdata}, 0);
    check("arst_trig_out", {31'b0, trig_out}, 0);
    check("arst_clk_out1", {31'b0, clk_out1}, 0);
    cycles(3);
    aresetn = 1'b1;
    cycles(50);
    trig = 1'b0; cycles(40);

    check("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
